// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    STALL,
    HALT,
    JFETCH,
    JLOAD
  } fetch_state_e;

  typedef enum logic [1:0] {
    SC_NONE = 2'b00,
    SC_RD   = 2'b01,
    SC_WR   = 2'b10,
    SC_HALT = 2'b11
  } state_ctrl_e;

  localparam logic [7:0] OP_JMP = 8'h20;

  localparam int STALL_CNT_W = 2;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - ROM, decoder and control signals between the fetch unit and its environment
interface fetch_unit_if;

  logic       run;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] opcode;
  logic       opcode_valid;
  logic [1:0] state_control;
  logic [7:0] pc;
  logic       halted;

  // fetch unit side
  modport master (
    input  run,
    input  rom_data,
    input  state_control,
    output rom_en,
    output rom_addr,
    output opcode,
    output opcode_valid,
    output pc,
    output halted
  );

  // ROM / decoder / control side
  modport slave (
    output run,
    output rom_data,
    output state_control,
    input  rom_en,
    input  rom_addr,
    input  opcode,
    input  opcode_valid,
    input  pc,
    input  halted
  );

endinterface

// File: rtl/fetch_unit_pc.sv
// rtl/fetch_unit_pc.sv - 8-bit program counter with increment, load and async clear
module program_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] pc_o
);

  logic [7:0] pc_q;
  logic [7:0] pc_d;

  // load wins over increment; increment wraps 0xFF -> 0x00
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + 8'd1;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= 8'h00;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer; JMP handling enabled by FETCH_JUMP_EN
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned STALL_RD = 1,
  parameter int unsigned STALL_WR = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam logic [STALL_CNT_W-1:0] RD_CNT = STALL_CNT_W'(STALL_RD);
  localparam logic [STALL_CNT_W-1:0] WR_CNT = STALL_CNT_W'(STALL_WR);

  fetch_state_e            state_q;
  logic [STALL_CNT_W-1:0]  cnt_q;
  logic                    rom_en_q;
  logic                    opcode_valid_q;
  logic [7:0]              opcode_q;
  logic                    halted_q;
  logic [7:0]              pc;
  logic                    is_jmp;
  state_ctrl_e             sc;

  assign sc = state_ctrl_e'(bus.state_control);

`ifdef FETCH_JUMP_EN
  assign is_jmp = (opcode_q == OP_JMP);
`else
  assign is_jmp = 1'b0;
`endif

  // pc advances in LOAD; a jump target from ROM replaces it in JLOAD
  program_counter u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (state_q == LOAD),
    .load_i     (state_q == JLOAD),
    .load_val_i (bus.rom_data),
    .pc_o       (pc)
  );

  // sequencer FSM; rom_en and opcode_valid are set on entry to the state that owns them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rom_en_q       <= 1'b0;
      opcode_valid_q <= 1'b0;
      opcode_q       <= 8'h00;
      halted_q       <= 1'b0;
    end else begin
      rom_en_q       <= 1'b0;
      opcode_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.run) begin
            state_q  <= FETCH;
            rom_en_q <= 1'b1;
          end
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          opcode_q       <= bus.rom_data;
          opcode_valid_q <= 1'b1;
          state_q        <= ISSUE;
        end
        ISSUE: begin
          if (is_jmp) begin
            state_q  <= JFETCH;
            rom_en_q <= 1'b1;
          end else begin
            case (sc)
              SC_NONE: begin
                state_q  <= bus.run ? FETCH : IDLE;
                rom_en_q <= bus.run;
              end
              SC_RD: begin
                cnt_q   <= RD_CNT;
                state_q <= STALL;
              end
              SC_WR: begin
                cnt_q   <= WR_CNT;
                state_q <= STALL;
              end
              SC_HALT: begin
                halted_q <= 1'b1;
                state_q  <= HALT;
              end
            endcase
          end
        end
        STALL: begin
          if (cnt_q == STALL_CNT_W'(1)) begin
            state_q  <= bus.run ? FETCH : IDLE;
            rom_en_q <= bus.run;
          end else begin
            cnt_q <= cnt_q - STALL_CNT_W'(1);
          end
        end
        HALT:   state_q <= HALT;
        JFETCH: state_q <= JLOAD;
        JLOAD: begin
          state_q  <= FETCH;
          rom_en_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rom_en       = rom_en_q;
  assign bus.rom_addr     = pc;
  assign bus.opcode       = opcode_q;
  assign bus.opcode_valid = opcode_valid_q;
  assign bus.pc           = pc;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a timing/sequence reference model
module tb_fetch_unit;

  localparam int STALL_RD = 1;
  localparam int STALL_WR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.STALL_RD(STALL_RD), .STALL_WR(STALL_WR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] rom    [256];
  logic [1:0] sc_tab [256];

  // synchronous ROM, one-cycle read latency
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
  end

  // decoder stand-in: state_control is a pure function of the held opcode
  always_comb bus.state_control = sc_tab[bus.opcode];

  int         checks = 0;
  int         errors = 0;
  int         since;
  int         next_gap;
  logic [7:0] model_pc;
  logic [7:0] prev_op;
  logic [7:0] jaddr;
  bit         jpend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    since++;
  endtask

  task automatic watch();
    if (!bus.opcode_valid) check("op_stable", bus.opcode, prev_op);
    if (bus.rom_en) begin
      if (jpend) begin
        check("jfetch_addr", bus.rom_addr, jaddr);
        jpend = 1'b0;
      end else begin
        check("fetch_addr", bus.rom_addr, model_pc);
      end
    end
  endtask

  task automatic do_reset(input logic run_v);
    rst_n   = 1'b0;
    bus.run = 1'b0;
    repeat (2) step();
    bus.run  = run_v;
    rst_n    = 1'b1;
    since    = 0;
    model_pc = 8'h00;
    prev_op  = 8'h00;
    next_gap = 3;
    jpend    = 1'b0;
  endtask

  task automatic expect_issues(input int n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] op;
      logic [1:0] sc;
      do begin
        step();
        watch();
      end while (!bus.opcode_valid && since < 40);
      check("issue_seen", bus.opcode_valid, 1);
      if (!bus.opcode_valid) return;
      check("issue_gap", since, next_gap);
      op = rom[model_pc];
      check("issue_opcode", bus.opcode, op);
      model_pc = model_pc + 8'd1;
      check("issue_pc", bus.pc, model_pc);
      prev_op = op;
      since   = 0;
      sc      = sc_tab[op];
`ifdef FETCH_JUMP_EN
      if (op == 8'h20) begin
        jpend    = 1'b1;
        jaddr    = model_pc;
        model_pc = rom[jaddr];
        next_gap = 5;
        continue;
      end
`endif
      next_gap = 3 + ((sc == 2'b01) ? STALL_RD : (sc == 2'b10) ? STALL_WR : 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]    = 8'h00;
      sc_tab[i] = 2'b00;
    end

    // reset values while run is already high
    rst_n   = 1'b0;
    bus.run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", bus.pc, 8'h00);
    check("rst_opcode", bus.opcode, 8'h00);
    check("rst_valid", bus.opcode_valid, 0);
    check("rst_rom_en", bus.rom_en, 0);
    check("rst_halted", bus.halted, 0);

    // straight-line program, then read/write stalls, then run dropped in a stall
    rom[0] = 8'h01; rom[1] = 8'h0C; rom[2] = 8'h05;
    rom[3] = 8'h18; rom[4] = 8'h18; rom[5] = 8'h05;
    rom[6] = 8'h18; rom[7] = 8'h0C;
    sc_tab[8'h18] = 2'b01;
    do_reset(1'b1);
    expect_issues(3);
    check("pc_after_three", bus.pc, 8'h03);
    expect_issues(1);
    step();
    watch();
    sc_tab[8'h18] = 2'b10;
    expect_issues(2);
    sc_tab[8'h18] = 2'b01;
    expect_issues(1);
    bus.run = 1'b0;
    repeat (8) begin
      step();
      watch();
      check("parked_rom_en", bus.rom_en, 0);
      check("parked_valid", bus.opcode_valid, 0);
    end
    check("parked_pc", bus.pc, 8'h07);
    next_gap = since + 3;
    bus.run  = 1'b1;
    expect_issues(1);

    // random program over the whole ROM, wrapping pc past 0xFF
    for (int i = 0; i < 256; i++) begin
      sc_tab[i] = 2'($urandom_range(0, 2));
      rom[i]    = 8'($urandom);
`ifdef FETCH_JUMP_EN
      if (rom[i] == 8'h20) rom[i] = 8'h21;
`endif
    end
    do_reset(1'b1);
    expect_issues(255);
    check("pc_at_ff", bus.pc, 8'hFF);
    expect_issues(1);
    check("pc_wrapped", bus.pc, 8'h00);
    expect_issues(2);

    // opcode 0x20: jump when enabled, ordinary instruction otherwise
    for (int i = 0; i < 256; i++) sc_tab[i] = 2'b00;
    rom[0] = 8'h20; rom[1] = 8'h40; rom[2] = 8'h0C;
    rom[8'h40] = 8'h01; rom[8'h41] = 8'h05;
    do_reset(1'b1);
    expect_issues(3);

    // halt is sticky, ignores run, and clears only on async reset
    rom[0] = 8'h01; rom[1] = 8'hEE;
    sc_tab[8'hEE] = 2'b11;
    do_reset(1'b1);
    expect_issues(2);
    step();
    check("halted_set", bus.halted, 1);
    repeat (10) begin
      step();
      check("halt_rom_en", bus.rom_en, 0);
      check("halt_valid", bus.opcode_valid, 0);
      check("halt_sticky", bus.halted, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_halted", bus.halted, 0);
    check("arst_pc", bus.pc, 8'h00);
    check("arst_opcode", bus.opcode, 8'h00);
    check("arst_rom_en", bus.rom_en, 0);
    check("arst_valid", bus.opcode_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
